// File: rtl/dot_engine.sv
// dot_engine: multi-lane signed/unsigned dot product of two captured operand vectors.
// A start in IDLE captures the operands, CALC folds LANES products per cycle into the
// accumulator, and DONE presents the result with a one-cycle done pulse.
module dot_engine #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LEN    = 8,
    parameter int unsigned LANES  = 2,
    parameter int unsigned ACC_W  = 2 * DATA_W + $clog2(LEN)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [LEN*DATA_W-1:0]       a,
    input  logic [LEN*DATA_W-1:0]       b,
    input  logic [$clog2(LEN+1)-1:0]    len,
    input  logic                        is_signed,
    input  logic                        start,
    output logic                        busy,
    output logic                        done,
    output logic                        err,
    output logic signed [ACC_W-1:0]     result
);

    localparam int unsigned LEN_W  = $clog2(LEN + 1);
    localparam int unsigned GRP_W  = $clog2(LEN + 1);
    localparam int unsigned IDX_W  = $clog2(2 * LEN + 1);
    localparam int unsigned SEL_W  = (LEN > 1) ? $clog2(LEN) : 1;
    localparam int unsigned PROD_W = 2 * DATA_W + 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                    state_q, state_d;

    logic [DATA_W-1:0]         a_q [LEN];
    logic [DATA_W-1:0]         b_q [LEN];
    logic [LEN_W-1:0]          len_q;
    logic                      is_signed_q;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic [GRP_W-1:0]          grp_q, grp_d;
    logic signed [ACC_W-1:0]   result_q, result_d;
    logic                      err_q, err_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      capture_c;

    logic                      legal_c;
    logic                      last_c;
    logic [IDX_W-1:0]          base_c;
    logic [IDX_W-1:0]          lane_idx_c [LANES];
    logic signed [DATA_W:0]    op_a_c [LANES];
    logic signed [DATA_W:0]    op_b_c [LANES];
    logic signed [PROD_W-1:0]  prod_c [LANES];
    logic signed [ACC_W-1:0]   lane_sum_c;

    assign busy   = busy_q;
    assign done   = done_q;
    assign err    = err_q;
    assign result = result_q;

    // A request is legal only for 1..LEN active elements.
    assign legal_c = (len != '0) && (len <= LEN_W'(LEN));

    // Per-lane products for the current group; lanes at or beyond len_q contribute 0.
    always_comb begin
        base_c     = IDX_W'(grp_q) * IDX_W'(LANES);
        lane_sum_c = '0;
        for (int l = 0; l < LANES; l++) begin
            lane_idx_c[l] = base_c + IDX_W'(l);
            op_a_c[l]     = '0;
            op_b_c[l]     = '0;
            if (lane_idx_c[l] < IDX_W'(len_q)) begin
                op_a_c[l] = {is_signed_q & a_q[SEL_W'(lane_idx_c[l])][DATA_W-1],
                             a_q[SEL_W'(lane_idx_c[l])]};
                op_b_c[l] = {is_signed_q & b_q[SEL_W'(lane_idx_c[l])][DATA_W-1],
                             b_q[SEL_W'(lane_idx_c[l])]};
            end
            prod_c[l]  = PROD_W'(op_a_c[l]) * PROD_W'(op_b_c[l]);
            lane_sum_c = lane_sum_c + ACC_W'(prod_c[l]);
        end
        last_c = (base_c + IDX_W'(LANES)) >= IDX_W'(len_q);
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = legal_c ? CALC : DONE;
                end
            end
            CALC: begin
                if (last_c) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and registered-output next values.
    always_comb begin
        capture_c = 1'b0;
        acc_d     = acc_q;
        grp_d     = grp_q;
        result_d  = result_q;
        err_d     = err_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    capture_c = 1'b1;
                    acc_d     = '0;
                    grp_d     = '0;
                    if (!legal_c) begin
                        result_d = '0;
                        err_d    = 1'b1;
                    end
                end
            end
            CALC: begin
                acc_d = acc_q + lane_sum_c;
                grp_d = grp_q + GRP_W'(1);
                if (last_c) begin
                    result_d = acc_q + lane_sum_c;
                    err_d    = 1'b0;
                end
            end
            default: ;
        endcase
        busy_d = (state_d == CALC);
        done_d = (state_d == DONE);
    end

    // Operand capture, accumulator and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LEN; i++) begin
                a_q[i] <= '0;
                b_q[i] <= '0;
            end
            len_q       <= '0;
            is_signed_q <= 1'b0;
            acc_q       <= '0;
            grp_q       <= '0;
            result_q    <= '0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            if (capture_c) begin
                for (int i = 0; i < LEN; i++) begin
                    a_q[i] <= a[i*DATA_W +: DATA_W];
                    b_q[i] <= b[i*DATA_W +: DATA_W];
                end
                len_q       <= len;
                is_signed_q <= is_signed;
            end
            acc_q    <= acc_d;
            grp_q    <= grp_d;
            result_q <= result_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

endmodule

// File: tb/tb_dot_engine.sv
// tb_dot_engine: directed vectors with hand-computed dot products and latencies.
module tb_dot_engine;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned LEN    = 8;
    localparam int unsigned LANES  = 2;
    localparam int unsigned ACC_W  = 2 * DATA_W + $clog2(LEN);
    localparam int unsigned LEN_W  = $clog2(LEN + 1);

    logic                     clk;
    logic                     rst;
    logic [LEN*DATA_W-1:0]    a;
    logic [LEN*DATA_W-1:0]    b;
    logic [LEN_W-1:0]         len;
    logic                     is_signed;
    logic                     start;
    logic                     busy;
    logic                     done;
    logic                     err;
    logic signed [ACC_W-1:0]  result;

    logic [DATA_W-1:0]        av [LEN];
    logic [DATA_W-1:0]        bv [LEN];

    int checks   = 0;
    int failures = 0;
    int lat;
    int bcnt;
    int cnt;

    dot_engine #(
        .DATA_W (DATA_W),
        .LEN    (LEN),
        .LANES  (LANES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .len       (len),
        .is_signed (is_signed),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .result    (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic load_vec();
        for (int i = 0; i < LEN; i++) begin
            a[i*DATA_W +: DATA_W] = av[i];
            b[i*DATA_W +: DATA_W] = bv[i];
        end
    endtask

    task automatic fill(input logic [DATA_W-1:0] a_base, input logic [DATA_W-1:0] a_step,
                        input logic [DATA_W-1:0] b_base, input logic [DATA_W-1:0] b_step);
        for (int i = 0; i < LEN; i++) begin
            av[i] = a_base + a_step * DATA_W'(i);
            bv[i] = b_base + b_step * DATA_W'(i);
        end
    endtask

    // One-cycle start pulse, then wait (bounded) for done; lat counts cycles after the start cycle.
    task automatic run_op(input logic [LEN_W-1:0] l, input logic sgn,
                          output int lat_o, output int bcnt_o);
        @(negedge clk);
        load_vec();
        len       = l;
        is_signed = sgn;
        start     = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat_o  = 0;
        bcnt_o = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (busy) bcnt_o++;
            if (done) begin
                lat_o = c;
                break;
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        a         = '0;
        b         = '0;
        len       = '0;
        is_signed = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy",   128'(busy),   128'd0);
        check("rst_done",   128'(done),   128'd0);
        check("rst_err",    128'(err),    128'd0);
        check("rst_result", 128'(result), 128'd0);
        rst = 1'b0;

        // a=1..8, b=1..8 -> 204
        fill(1, 1, 1, 1);
        run_op(8, 1'b1, lat, bcnt);
        check("seq_result", 128'(result), 128'd204);
        check("seq_lat",    128'(lat),    128'd5);
        check("seq_busy",   128'(bcnt),   128'd4);
        check("seq_err",    128'(err),    128'd0);

        // all -1 times 3, signed -> -24
        fill(32'hFFFF_FFFF, 0, 3, 0);
        run_op(8, 1'b1, lat, bcnt);
        check("neg_result", 128'(result), -128'sd24);
        // same bits unsigned -> 0xFFFFFFFF*3*8
        run_op(8, 1'b0, lat, bcnt);
        check("uns_result", 128'(result), 128'd103079215080);

        // len=3 masks lane 3: 1*2+2*2+3*2 = 12
        fill(1, 1, 2, 0);
        run_op(3, 1'b1, lat, bcnt);
        check("len3_result", 128'(result), 128'd12);
        check("len3_lat",    128'(lat),    128'd3);
        run_op(1, 1'b1, lat, bcnt);
        check("len1_result", 128'(result), 128'd2);
        check("len1_lat",    128'(lat),    128'd2);

        // illegal lengths
        run_op(0, 1'b1, lat, bcnt);
        check("len0_lat",    128'(lat),    128'd1);
        check("len0_err",    128'(err),    128'd1);
        check("len0_result", 128'(result), 128'd0);
        check("len0_busy",   128'(bcnt),   128'd0);
        run_op(9, 1'b1, lat, bcnt);
        check("len9_lat",    128'(lat),    128'd1);
        check("len9_err",    128'(err),    128'd1);
        check("len9_result", 128'(result), 128'd0);
        run_op(2, 1'b1, lat, bcnt);
        check("legal_err",    128'(err),    128'd0);
        check("legal_result", 128'(result), 128'd6);

        // most-negative operands: 8 * 2^62 = 2^65
        fill(32'h8000_0000, 0, 32'h8000_0000, 0);
        run_op(8, 1'b1, lat, bcnt);
        check("minneg_result", 128'(result), 128'h2_0000_0000_0000_0000);
        check("minneg_lat",    128'(lat),    128'd5);

        // inputs changed and start pulsed during CALC must not disturb the operation
        fill(1, 1, 1, 1);
        @(negedge clk);
        load_vec();
        len       = 8;
        is_signed = 1'b1;
        start     = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 2) begin
                fill(7, 0, 7, 0);
                load_vec();
                len   = 3;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                lat = c;
                break;
            end
        end
        check("iso_result", 128'(result), 128'd204);
        check("iso_lat",    128'(lat),    128'd5);
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (busy || done) cnt++;
        end
        check("iso_no_extra", 128'(cnt),    128'd0);
        check("iso_hold",     128'(result), 128'd204);

        // start held high is re-accepted in the first IDLE cycle (len=1: CALC, DONE, IDLE, CALC)
        fill(1, 1, 2, 0);
        @(negedge clk);
        load_vec();
        len       = 1;
        is_signed = 1'b1;
        start     = 1'b1;
        @(negedge clk);
        check("held_c1_busy", 128'(busy), 128'd1);
        @(negedge clk);
        check("held_c2_done", 128'(done), 128'd1);
        @(negedge clk);
        check("held_c3_busy", 128'(busy), 128'd0);
        @(negedge clk);
        check("held_c4_busy", 128'(busy), 128'd1);
        start = 1'b0;
        repeat (4) @(negedge clk);

        // reset mid-CALC aborts with all outputs cleared immediately and no done
        fill(1, 1, 1, 1);
        @(negedge clk);
        load_vec();
        len       = 8;
        is_signed = 1'b1;
        start     = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_busy",   128'(busy),   128'd0);
        check("arst_done",   128'(done),   128'd0);
        check("arst_err",    128'(err),    128'd0);
        check("arst_result", 128'(result), 128'd0);
        @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (done || busy) cnt++;
        end
        check("arst_no_done", 128'(cnt), 128'd0);
        run_op(8, 1'b1, lat, bcnt);
        check("post_rst_result", 128'(result), 128'd204);
        check("post_rst_lat",    128'(lat),    128'd5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
